// File: rtl/rng_pkg.sv
// Shared types and constants for the PRNG mask packing path.
package rng_pkg;

  localparam int WORD_W         = 32;
  localparam int MASK_W         = 128;
  localparam int WORDS_PER_MASK = 4;

  typedef logic [MASK_W-1:0] mask_t;

endpackage

// File: rtl/mask_fifo.sv
// Show-ahead FIFO of 128-bit masks. Occupancy is tracked with an explicit
// level counter; full/empty come from the level so that pointers can wrap
// freely. A push while full is only honoured together with a pop.
module mask_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  mask_t                    wdata,
  input  logic                     pop,
  output mask_t                    rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  mask_t              mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign level     = level_r;

  // Head of the queue, forced to zero when nothing is buffered.
  always_comb begin
    rdata = {MASK_W{1'b0}};
    if (!empty) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = {MASK_W{1'b0}};
    end
  end

  // Storage array write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/rng_mask_packer.sv
// Packs four consecutive PRNG words into a 128-bit mask, buffers masks in a
// small FIFO and flags zero or repeated PRNG words with a sticky error.
module rng_mask_packer
  import rng_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DISCARD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_W-1:0]        rng_in,
  input  logic                     fill_en,
  output mask_t                    mask_out,
  output logic                     mask_valid,
  input  logic                     mask_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     stuck_err
);

  localparam int CNT_W  = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int PACK_W = MASK_W - WORD_W;

  logic [CNT_W-1:0]  disc_cnt_r;
  logic [1:0]        word_cnt_r;
  logic [PACK_W-1:0] pack_r;
  logic [WORD_W-1:0] prev_r;
  logic              have_prev_r;
  logic              stuck_r;

  logic              discard_done_s;
  logic              last_word_s;
  logic              pop_s;
  logic              push_s;
  logic              capture_s;
  logic              bad_word_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  mask_t             pack_next_s;

  assign discard_done_s = (disc_cnt_r == CNT_W'(DISCARD));
  assign last_word_s    = (word_cnt_r == 2'(WORDS_PER_MASK - 1));
  assign mask_valid     = !fifo_empty_s;
  assign pop_s          = mask_valid && mask_ready;
  // The closing word is held off only when it could not be written.
  assign capture_s      = fill_en && discard_done_s && !(last_word_s && fifo_full_s && !pop_s);
  assign push_s         = capture_s && last_word_s;
  assign pack_next_s    = {pack_r, rng_in};
  assign stuck_err      = stuck_r;

  // Health check: zero word always bad, repeat only once a previous word exists.
  always_comb begin
    bad_word_s = 1'b0;
    if (rng_in == {WORD_W{1'b0}}) begin
      bad_word_s = 1'b1;
    end else if (have_prev_r && (rng_in == prev_r)) begin
      bad_word_s = 1'b1;
    end else begin
      bad_word_s = 1'b0;
    end
  end

  // Start-up discard counter, saturates at DISCARD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_cnt_r <= {CNT_W{1'b0}};
    end else if (!discard_done_s) begin
      disc_cnt_r <= disc_cnt_r + CNT_W'(1);
    end else begin
      disc_cnt_r <= disc_cnt_r;
    end
  end

  // Word packer: shifts captured words in, oldest word ends up in the MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_r     <= {PACK_W{1'b0}};
      word_cnt_r <= 2'd0;
    end else if (capture_s) begin
      pack_r     <= pack_next_s[PACK_W-1:0];
      word_cnt_r <= word_cnt_r + 2'd1;
    end else begin
      pack_r     <= pack_r;
      word_cnt_r <= word_cnt_r;
    end
  end

  // Sticky health flag and previous-word tracking, updated on capture only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r      <= {WORD_W{1'b0}};
      have_prev_r <= 1'b0;
      stuck_r     <= 1'b0;
    end else if (capture_s) begin
      prev_r      <= rng_in;
      have_prev_r <= 1'b1;
      stuck_r     <= stuck_r | bad_word_s;
    end else begin
      prev_r      <= prev_r;
      have_prev_r <= have_prev_r;
      stuck_r     <= stuck_r;
    end
  end

  mask_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (pack_next_s),
    .pop   (pop_s),
    .rdata (mask_out),
    .level (level),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule
